// File: rtl/seg_pkg.sv
// Shared constants and byte-slicing helper for the 7-segment scan controller.
package seg_pkg;

  localparam int unsigned SEG_W     = 8;
  localparam int unsigned SEG_SH    = $clog2(SEG_W);
  localparam logic [SEG_W-1:0] SEG_OFF = 8'h00;

  // Upper bound on N_DIG supported by digit_byte.
  localparam int unsigned MAX_DIG   = 32;
  localparam int unsigned DIG_IDX_W = $clog2(MAX_DIG);
  localparam int unsigned EXT_W     = SEG_W * MAX_DIG;

  typedef logic [SEG_W-1:0]     seg_byte_t;
  typedef logic [DIG_IDX_W-1:0] dig_idx_t;

  function automatic seg_byte_t digit_byte(input logic [EXT_W-1:0] vec,
                                           input dig_idx_t idx);
    logic [DIG_IDX_W+SEG_SH-1:0] base;
    base = {idx, {SEG_SH{1'b0}}};
    return vec[base +: SEG_W];
  endfunction

endpackage

// File: rtl/seg_tick_div.sv
// Free-running modulo-DIV counter; tick_o marks the last cycle of each period.
module seg_tick_div #(
  parameter int unsigned DIV = 100000,
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             tick_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CNT_W'(DIV - 1));
    cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scan controller: dead time, PWM brightness, blank/blink
// masks and frame-synchronous double-buffered pattern loading.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned N_DIG     = 8,
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned PWM_BITS  = 4,
  parameter int unsigned BLINK_DIV = 50
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SEG_W*N_DIG-1:0] seg_in,
  input  logic                   load,
  output logic                   load_ack,
  input  logic [N_DIG-1:0]       blank_mask,
  input  logic [N_DIG-1:0]       blink_mask,
  input  logic [PWM_BITS-1:0]    bright,
  output logic [N_DIG-1:0]       seg_en,
  output logic [SEG_W-1:0]       seg_out,
  output logic                   frame_start
);

  localparam int unsigned IDX_W  = (N_DIG > 1)     ? $clog2(N_DIG)     : 1;
  localparam int unsigned SLOT_W = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic              tick;
  logic [SLOT_W-1:0] slot;
  logic              frame_end;
  logic              pwm_on;
  logic [EXT_W-1:0]  disp_ext;

  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PWM_BITS-1:0]    pwm_q, pwm_d;
  logic [BLK_W-1:0]       blk_cnt_q, blk_cnt_d;
  logic                   phase_q, phase_d;
  logic [SEG_W*N_DIG-1:0] disp_q, disp_d;
  logic [SEG_W*N_DIG-1:0] stage_q, stage_d;
  logic                   pend_q, pend_d;
  logic [N_DIG-1:0]       seg_en_q, seg_en_d;
  logic [SEG_W-1:0]       seg_out_q, seg_out_d;
  logic                   fs_q, fs_d;
  logic                   ack_q, ack_d;

  seg_tick_div #(.DIV(SCAN_DIV)) u_slot_div (
    .clk_i  (clk),
    .rst_ni (rst),
    .tick_o (tick),
    .cnt_o  (slot)
  );

  assign disp_ext = EXT_W'(disp_q);

  always_comb begin
    frame_end = tick & (idx_q == IDX_W'(N_DIG - 1));

    idx_d = idx_q;
    if (tick) idx_d = frame_end ? '0 : idx_q + IDX_W'(1);

    pwm_d = pwm_q + PWM_BITS'(1);

    blk_cnt_d = blk_cnt_q;
    phase_d   = phase_q;
    if (frame_end) begin
      if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
        blk_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end

    // A load landing in the boundary cycle bypasses staging and shares the ack.
    disp_d  = disp_q;
    stage_d = stage_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    if (frame_end && (pend_q || load)) begin
      disp_d = load ? seg_in : stage_q;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end else if (load) begin
      stage_d = seg_in;
      pend_d  = 1'b1;
    end

    pwm_on = (bright == '1) || (pwm_q < bright);

    seg_en_d = '1;
    for (int k = 0; k < N_DIG; k++) begin
      seg_en_d[k] = !((idx_q == IDX_W'(k)) && (slot >= SLOT_W'(BLANK_CYC)) &&
                      pwm_on && !blank_mask[k] && !(blink_mask[k] && phase_q));
    end

    seg_out_d = digit_byte(disp_ext, DIG_IDX_W'(idx_q));
    fs_d      = frame_end;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q     <= '0;
      pwm_q     <= '0;
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
      disp_q    <= '0;
      stage_q   <= '0;
      pend_q    <= 1'b0;
      seg_en_q  <= '1;
      seg_out_q <= SEG_OFF;
      fs_q      <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      pwm_q     <= pwm_d;
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
      disp_q    <= disp_d;
      stage_q   <= stage_d;
      pend_q    <= pend_d;
      seg_en_q  <= seg_en_d;
      seg_out_q <= seg_out_d;
      fs_q      <= fs_d;
      ack_q     <= ack_d;
    end
  end

  assign seg_en      = seg_en_q;
  assign seg_out     = seg_out_q;
  assign frame_start = fs_q;
  assign load_ack    = ack_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with N_DIG=4, SCAN_DIV=8, BLANK_CYC=2, PWM_BITS=2, BLINK_DIV=2.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] seg_in = '0;
  logic        load = 1'b0;
  logic        load_ack;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic [1:0]  bright = '0;
  logic [3:0]  seg_en;
  logic [7:0]  seg_out;
  logic        frame_start;

  seg_scan_mux #(
    .N_DIG(4), .SCAN_DIV(8), .BLANK_CYC(2), .PWM_BITS(2), .BLINK_DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .load(load), .load_ack(load_ack),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .bright(bright),
    .seg_en(seg_en), .seg_out(seg_out), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  int ack_seen = 0, ack_last = -1, fs_seen = 0, fs_last = -1, onehot_bad = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  en;
    logic [7:0]  so;
    logic        fs;
  } vec_t;

  typedef struct packed {
    logic [1:0]       br;
    logic [3:0]       blank;
    logic [3:0]       blink;
    logic [3:0][2:0]  exp;
  } frame_t;

  vec_t   tbl[11];
  frame_t frm[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (load_ack) begin ack_seen++; ack_last = cyc; end
    if (frame_start) begin fs_seen++; fs_last = cyc; end
    if ($countones(~seg_en) > 1) onehot_bad++;
  endtask

  initial begin
    int en_bad;
    int base;
    int cnt[4];
    int fsc;

    tbl[0]  = '{cyc:33, en:4'b1111, so:8'h11, fs:1'b0};
    tbl[1]  = '{cyc:34, en:4'b1111, so:8'h11, fs:1'b0};
    tbl[2]  = '{cyc:35, en:4'b1110, so:8'h11, fs:1'b0};
    tbl[3]  = '{cyc:40, en:4'b1110, so:8'h11, fs:1'b0};
    tbl[4]  = '{cyc:41, en:4'b1111, so:8'h22, fs:1'b0};
    tbl[5]  = '{cyc:43, en:4'b1101, so:8'h22, fs:1'b0};
    tbl[6]  = '{cyc:48, en:4'b1101, so:8'h22, fs:1'b0};
    tbl[7]  = '{cyc:51, en:4'b1011, so:8'h33, fs:1'b0};
    tbl[8]  = '{cyc:59, en:4'b0111, so:8'h44, fs:1'b0};
    tbl[9]  = '{cyc:64, en:4'b0111, so:8'h44, fs:1'b1};
    tbl[10] = '{cyc:65, en:4'b1111, so:8'h11, fs:1'b0};

    // Per-frame on-cycle counts per digit, exp[3]..exp[0] = digit 3..0.
    frm[0] = '{br:2'd1, blank:4'h0, blink:4'h0, exp:{3'd1, 3'd1, 3'd1, 3'd1}};
    frm[1] = '{br:2'd2, blank:4'h0, blink:4'h0, exp:{3'd2, 3'd2, 3'd2, 3'd2}};
    frm[2] = '{br:2'd0, blank:4'h0, blink:4'h0, exp:{3'd0, 3'd0, 3'd0, 3'd0}};
    frm[3] = '{br:2'd3, blank:4'h4, blink:4'h0, exp:{3'd6, 3'd0, 3'd6, 3'd6}};
    frm[4] = '{br:2'd3, blank:4'h0, blink:4'h1, exp:{3'd6, 3'd6, 3'd6, 3'd0}};
    frm[5] = '{br:2'd3, blank:4'h0, blink:4'h1, exp:{3'd6, 3'd6, 3'd6, 3'd6}};
    frm[6] = '{br:2'd3, blank:4'h0, blink:4'h1, exp:{3'd6, 3'd6, 3'd6, 3'd6}};
    frm[7] = '{br:2'd3, blank:4'h0, blink:4'h1, exp:{3'd6, 3'd6, 3'd6, 3'd0}};
    frm[8] = '{br:2'd3, blank:4'h0, blink:4'h1, exp:{3'd6, 3'd6, 3'd6, 3'd0}};
    frm[9] = '{br:2'd3, blank:4'h0, blink:4'h1, exp:{3'd6, 3'd6, 3'd6, 3'd6}};

    repeat (3) step();
    cyc = 0; ack_seen = 0; fs_seen = 0; onehot_bad = 0;

    check("rst_seg_en", 32'(seg_en), 32'h0000000F);
    check("rst_seg_out", 32'(seg_out), 32'h00);
    check("rst_load_ack", 32'(load_ack), 32'h0);
    check("rst_frame_start", 32'(frame_start), 32'h0);

    // First frame: bright 0 keeps enables off while the load waits for the boundary.
    rst = 1'b1; bright = 2'd0; load = 1'b1; seg_in = 32'h44332211;
    step();
    load = 1'b0; seg_in = 32'hFFFFFFFF;
    en_bad = 0;
    for (int i = 0; i < 40 && !load_ack; i++) begin
      if (seg_en !== 4'hF) en_bad++;
      step();
    end
    check("first_frame_dark", 32'(en_bad), 32'h0);
    check("first_ack_cycle", 32'(cyc), 32'd32);
    check("first_ack_fs", 32'(frame_start), 32'h1);
    check("no_fs_on_reset_exit", 32'(fs_seen), 32'd1);
    bright = 2'd3;

    for (int i = 0; i < 11; i++) begin
      while (cyc < int'(tbl[i].cyc)) step();
      check($sformatf("tbl%0d_seg_en", i), 32'(seg_en), 32'(tbl[i].en));
      check($sformatf("tbl%0d_seg_out", i), 32'(seg_out), 32'(tbl[i].so));
      check($sformatf("tbl%0d_fs", i), 32'(frame_start), 32'(tbl[i].fs));
    end

    while (cyc < 96) step();
    for (int f = 0; f < 10; f++) begin
      bright = frm[f].br; blank_mask = frm[f].blank; blink_mask = frm[f].blink;
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      fsc = 0;
      for (int i = 0; i < 32; i++) begin
        step();
        for (int k = 0; k < 4; k++) if (!seg_en[k]) cnt[k]++;
        if (frame_start) fsc++;
      end
      for (int k = 0; k < 4; k++)
        check($sformatf("frm%0d_dig%0d_on", f, k), 32'(cnt[k]), 32'(frm[f].exp[k]));
      check($sformatf("frm%0d_fs_count", f), 32'(fsc), 32'd1);
    end
    blank_mask = 4'h0; blink_mask = 4'h0; bright = 2'd3;

    // Two loads in one frame: latest wins, single ack after the boundary.
    while (cyc < 427) step();
    ack_seen = 0;
    load = 1'b1; seg_in = 32'h0000000A;
    step();
    load = 1'b0; seg_in = 32'hFFFFFFFF;
    while (cyc < 436) step();
    load = 1'b1; seg_in = 32'h0000000B;
    step();
    load = 1'b0; seg_in = 32'hFFFFFFFF;
    while (cyc < 449) step();
    check("dbl_load_ack_count", 32'(ack_seen), 32'd1);
    check("dbl_load_ack_cycle", 32'(ack_last), 32'd448);
    check("dbl_load_dig0", 32'(seg_out), 32'h0B);
    while (cyc < 457) step();
    check("dbl_load_dig1", 32'(seg_out), 32'h00);

    // Load presented exactly in the boundary cycle.
    while (cyc < 479) step();
    ack_seen = 0;
    load = 1'b1; seg_in = 32'hDDCCBBAA;
    step();
    load = 1'b0; seg_in = 32'hFFFFFFFF;
    check("bnd_load_ack", 32'(load_ack), 32'h1);
    check("bnd_load_fs", 32'(frame_start), 32'h1);
    step();
    check("bnd_load_dig0", 32'(seg_out), 32'hAA);
    check("bnd_load_ack_count", 32'(ack_seen), 32'd1);
    while (cyc < 489) step();
    check("bnd_load_dig1", 32'(seg_out), 32'hBB);

    // One-cycle reset mid-slot with a load pending.
    while (cyc < 490) step();
    load = 1'b1; seg_in = 32'h12345678;
    step();
    load = 1'b0; seg_in = 32'hFFFFFFFF;
    while (cyc < 495) step();
    rst = 1'b0;
    step();
    check("mid_rst_seg_en", 32'(seg_en), 32'h0000000F);
    check("mid_rst_seg_out", 32'(seg_out), 32'h00);
    check("mid_rst_ack", 32'(load_ack), 32'h0);
    check("mid_rst_fs", 32'(frame_start), 32'h0);
    rst = 1'b1;
    base = cyc; ack_seen = 0; fs_seen = 0;
    while (cyc < base + 3) step();
    check("restart_dig0_en", 32'(seg_en), 32'h0000000E);
    check("restart_dig0_out", 32'(seg_out), 32'h00);
    while (cyc < base + 40) step();
    check("restart_no_ack", 32'(ack_seen), 32'd0);
    check("restart_fs_count", 32'(fs_seen), 32'd1);
    check("restart_fs_cycle", 32'(fs_last - base), 32'd32);

    check("enable_onehot", 32'(onehot_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
